// File: rtl/instruction_fetch_pkg.sv
// Shared widths, assembly-FSM encoding and instruction-length decode for the
// instruction fetch unit.
package instruction_fetch_pkg;

  localparam int PC_W       = 24;
  localparam int WORD_W     = 16;
  localparam int INSTR_W    = 2 * WORD_W;
  localparam int IS32_BIT   = 15;
  localparam int SKID_DEPTH = 2;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } asm_state_e;

  function automatic logic is_32bit(input logic [WORD_W-1:0] word);
    return word[IS32_BIT];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order FIFO that catches memory responses while the decoder
// holds the output; flush empties it in one cycle.
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [SKID_DEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == 2'(SKID_DEPTH));
  assign empty     = (count_r == 2'd0);
  assign head_data = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_ok_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, data only
  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: streams 16-bit words, assembles 16/32-bit instructions,
// skid-buffers behind decoder stalls, handles branch redirects.
// Optional FETCH_STATS_EN adds the instr_count accepted-instruction counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 24'h000000
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [WORD_W-1:0]  imem_data,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               branch_valid,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_is32,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        instr_count
`endif
);

  logic [PC_W-1:0]    fetch_pc_r;
  logic [PC_W-1:0]    cons_pc_r;
  logic               inflight_r;
  logic               discard_r;
  logic [WORD_W-1:0]  lo_word_r;
  asm_state_e         state_r;
  asm_state_e         state_nxt_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [WORD_W-1:0]  fifo_head_s;
  logic               rsp_valid_s;
  logic               src_valid_s;
  logic [WORD_W-1:0]  src_word_s;
  logic               out_free_s;
  logic               emit_s;
  logic               latch_s;
  logic               consume_s;
  logic               push_s;
  logic               pop_s;
  logic [INSTR_W-1:0] emit_data_s;
  logic               emit_is32_s;
  logic [PC_W-1:0]    emit_pc_s;

  // Request whenever a buffer slot would remain for the response in flight.
  assign imem_req    = !reset && (fifo_empty_s || (!fifo_full_s && !inflight_r));
  assign imem_addr   = fetch_pc_r;
  assign rsp_valid_s = imem_valid && !discard_r;
  assign out_free_s  = !instr_valid || !stall;
  assign push_s      = rsp_valid_s && !(fifo_empty_s && consume_s);
  assign pop_s       = !fifo_empty_s && consume_s;

  fetch_skid_buffer #(.WIDTH(WORD_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (branch_valid),
    .push      (push_s),
    .push_data (imem_data),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Word source: buffered words drain ahead of a fresh response
  always_comb begin
    src_valid_s = 1'b0;
    src_word_s  = {WORD_W{1'b0}};
    if (!fifo_empty_s) begin
      src_valid_s = 1'b1;
      src_word_s  = fifo_head_s;
    end else if (rsp_valid_s) begin
      src_valid_s = 1'b1;
      src_word_s  = imem_data;
    end else begin
      src_valid_s = 1'b0;
    end
  end

  // Assembly FSM next state and emit decode
  always_comb begin
    state_nxt_s = state_r;
    emit_s      = 1'b0;
    latch_s     = 1'b0;
    emit_data_s = {INSTR_W{1'b0}};
    emit_is32_s = 1'b0;
    emit_pc_s   = cons_pc_r;
    case (state_r)
      ST_LOW: begin
        if (src_valid_s && is_32bit(src_word_s)) begin
          latch_s     = 1'b1;
          state_nxt_s = ST_HIGH;
        end else if (src_valid_s && out_free_s) begin
          emit_s      = 1'b1;
          emit_data_s = {{WORD_W{1'b0}}, src_word_s};
        end else begin
          state_nxt_s = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (src_valid_s && out_free_s) begin
          emit_s      = 1'b1;
          emit_data_s = {src_word_s, lo_word_r};
          emit_is32_s = 1'b1;
          emit_pc_s   = cons_pc_r - PC_W'(1);
          state_nxt_s = ST_LOW;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      default: state_nxt_s = ST_LOW;
    endcase
    consume_s = emit_s || latch_s;
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset || branch_valid) state_r <= ST_LOW;
    else                       state_r <= state_nxt_s;
  end

  // PCs, response tracking and the registered decoder outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r  <= RESET_PC;
      cons_pc_r   <= RESET_PC;
      inflight_r  <= 1'b0;
      discard_r   <= 1'b0;
      lo_word_r   <= {WORD_W{1'b0}};
      instr_valid <= 1'b0;
      instr_is32  <= 1'b0;
      instr_out   <= {INSTR_W{1'b0}};
      instr_pc    <= {PC_W{1'b0}};
    end else if (branch_valid) begin
      // The response to this cycle's old-path request arrives next cycle.
      fetch_pc_r  <= branch_target;
      cons_pc_r   <= branch_target;
      inflight_r  <= 1'b0;
      discard_r   <= imem_req;
      instr_valid <= 1'b0;
    end else begin
      if (imem_req)  fetch_pc_r <= fetch_pc_r + PC_W'(1);
      if (consume_s) cons_pc_r  <= cons_pc_r + PC_W'(1);
      if (latch_s)   lo_word_r  <= src_word_s;
      inflight_r <= imem_req;
      discard_r  <= 1'b0;
      if (out_free_s) begin
        instr_valid <= emit_s;
        if (emit_s) begin
          instr_out  <= emit_data_s;
          instr_is32 <= emit_is32_s;
          instr_pc   <= emit_pc_s;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  // Accepted-instruction counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset)                      instr_count <= 32'h0000_0000;
    else if (instr_valid && !stall) instr_count <= instr_count + 32'd1;
    else                            instr_count <= instr_count;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed memory images, expected
// instructions queued at issue time, monitor compares on each acceptance.
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] out;
    logic        is32;
    logic [23:0] pc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [23:0] branch_target = 24'h0;
  logic        imem_req;
  logic [23:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [31:0] instr_out;
  logic        instr_is32;
  logic        instr_valid;
  logic [23:0] instr_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] instr_count;
`endif

  exp_t        exp_q[$];
  logic [15:0] mem [logic [23:0]];
  int          checks = 0;
  int          failures = 0;
  exp_t        mon_cur;
  exp_t        mon_exp;
  exp_t        prev_s;
  logic        prev_held = 1'b0;

  instruction_fetch #(.RESET_PC(24'h000010)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr_out     (instr_out),
    .instr_is32    (instr_is32),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc)
`ifdef FETCH_STATS_EN
    ,
    .instr_count   (instr_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    else return 16'h0000;
  endfunction

  // One-cycle-latency instruction memory
  always @(posedge clock) begin
    imem_valid <= imem_req;
    imem_data  <= mem_rd(imem_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: hold-under-stall and in-order scoreboard on acceptance
  always @(negedge clock) begin
    if (reset) begin
      prev_held = 1'b0;
    end else if (instr_valid === 1'b1) begin
      mon_cur = {instr_out, instr_is32, instr_pc};
      if (prev_held) chk("hold", 64'(mon_cur), 64'(prev_s));
      if (stall === 1'b0 && exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        chk("instr", 64'(mon_cur), 64'(mon_exp));
      end
      prev_held = stall;
      prev_s    = mon_cur;
    end else begin
      prev_held = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] o, input logic is32, input logic [23:0] pc);
    exp_q.push_back({o, is32, pc});
  endtask

  task automatic do_branch(input logic [23:0] t);
    branch_valid  = 1'b1;
    branch_target = t;
    cyc(1);
    branch_valid  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cyc(1);
      n++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // One-cycle reset, then first request, outputs and start-up latency
  task automatic do_reset(input string name);
    reset = 1'b1;
    @(negedge clock);
    chk({name, "_req_in_reset"}, 64'(imem_req), 64'd0);
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h0000_0A10 + 32'(i), 1'b0, 24'h000010 + 24'(i));
    @(negedge clock);
    chk({name, "_out"}, 64'(instr_out), 64'd0);
    chk({name, "_valid"}, 64'(instr_valid), 64'd0);
    chk({name, "_is32"}, 64'(instr_is32), 64'd0);
    chk({name, "_pc"}, 64'(instr_pc), 64'd0);
    chk({name, "_first_req"}, 64'(imem_req), 64'd1);
    chk({name, "_first_addr"}, 64'(imem_addr), 64'h10);
    @(negedge clock);
    chk({name, "_lat_n1"}, 64'(instr_valid), 64'd0);
    @(negedge clock);
    chk({name, "_lat_n2"}, 64'(instr_valid), 64'd1);
    cyc(1);
    wait_drain(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[24'h000010 + 24'(i)] = 16'h0A10 + 16'(i);
    for (int i = 0; i < 4; i++) mem[24'(i)] = 16'h0001 + 16'(i);
    for (int i = 0; i < 12; i++) mem[24'h000020 + 24'(i)] = 16'h0020 + 16'(i);
    mem[24'h000030] = 16'h0030;
    mem[24'h000031] = 16'h8AAA;
    mem[24'h000032] = 16'h1BBB;
    mem[24'h000033] = 16'h0033;
    for (int i = 0; i < 3; i++) mem[24'h000100 + 24'(i)] = 16'h0100 + 16'(i);

    // Power-up reset
    cyc(3);
    @(negedge clock);
    chk("por_valid", 64'(instr_valid), 64'd0);
    chk("por_out", 64'(instr_out), 64'd0);
    cyc(1);
    do_reset("por");

    // Four 16-bit words from address 0, one per cycle
    do_branch(24'h000000);
    for (int i = 0; i < 4; i++) push(32'h0000_0001 + 32'(i), 1'b0, 24'(i));
    @(negedge clock);
    chk("seq_req", 64'(imem_req), 64'd1);
    chk("seq_addr", 64'(imem_addr), 64'd0);
    @(negedge clock);
    chk("seq_lat", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("seq_back_to_back", 64'(instr_valid), 64'd1);
    end
    cyc(1);
    wait_drain("seq");

    // 32-bit instruction assembly
    mem[24'h000000] = 16'h8123;
    mem[24'h000001] = 16'h4567;
    mem[24'h000002] = 16'h0005;
    do_branch(24'h000000);
    push(32'h4567_8123, 1'b1, 24'h000000);
    push(32'h0000_0005, 1'b0, 24'h000002);
    wait_drain("asm32");

    // 32-bit instruction straddling the PC wrap
    mem[24'hFFFFFF] = 16'h8001;
    mem[24'h000000] = 16'h0002;
    mem[24'h000001] = 16'h0003;
    do_branch(24'hFFFFFF);
    push(32'h0002_8001, 1'b1, 24'hFFFFFF);
    push(32'h0000_0003, 1'b0, 24'h000001);
    @(negedge clock);
    chk("wrap_addr0", 64'(imem_addr), 64'hFFFFFF);
    @(negedge clock);
    chk("wrap_addr1", 64'(imem_addr), 64'h0);
    cyc(1);
    wait_drain("wrap");

    // Five-cycle stall in a 16-bit stream
    do_branch(24'h000020);
    for (int i = 0; i < 12; i++) push(32'h0000_0020 + 32'(i), 1'b0, 24'h000020 + 24'(i));
    cyc(4);
    stall = 1'b1;
    cyc(4);
    @(negedge clock);
    chk("stall_req_off", 64'(imem_req), 64'd0);
    chk("stall_valid", 64'(instr_valid), 64'd1);
    @(posedge clock);
    #1;
    stall = 1'b0;
    wait_drain("stall");

    // Branch while HIGH and stalled discards latched and buffered words
    stall = 1'b1;
    do_branch(24'h000030);
    cyc(4);
    @(negedge clock);
    chk("br_pre_valid", 64'(instr_valid), 64'd1);
    chk("br_pre_out", 64'(instr_out), 64'h30);
    @(posedge clock);
    #1;
    do_branch(24'h000100);
    stall = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h0000_0100 + 32'(i), 1'b0, 24'h000100 + 24'(i));
    @(negedge clock);
    chk("br_valid_off", 64'(instr_valid), 64'd0);
    chk("br_req", 64'(imem_req), 64'd1);
    chk("br_addr", 64'(imem_addr), 64'h100);
    cyc(1);
    wait_drain("branch");

    // Reset pulse in the middle of a running stream
    cyc(2);
    do_reset("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
